imem_program_loader: RTL

//  Boot-time program loader upstream of the single-cycle core. Receives a byte

---
 rtl/imem_program_loader_pkg.sv | 35 +++
 rtl/imem_program_loader_byte_packer.sv | 45 ++++
 rtl/imem_program_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/imem_program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                program loader (FSM states, image framing sizes, helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Image framing: little-endian 32-bit header, little-endian 32-bit words
    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    // States whose bytes are assembled into 32-bit words (header or payload)
    function automatic logic packs_bytes(input state_t s);
        return (s == ST_HDR) || (s == ST_LOAD);
    endfunction

    // States from which a start pulse launches a new load
    function automatic logic can_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage : loader_pkg
`default_nettype wire

// File: rtl/imem_program_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles accepted bytes LSB-first into 32-bit words. A
//                2-bit lane counter tracks the byte position; word_valid_o
//                fires combinationally with the byte that completes a word,
//                so the consumer can register the word with 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer #(
    parameter int unsigned BYTES = 4
) (
    input  logic        clk_i,
    input  logic        resetl_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] C_LANE_LAST = 2'(BYTES - 1);

    logic [1:0]  lane_q;
    // Upper three bytes of the word in progress; the newest byte enters at the top
    logic [23:0] shift_q;
    logic        w_last;

    assign w_last       = (lane_q == C_LANE_LAST);
    assign word_valid_o = byte_valid_i && w_last;
    assign word_o       = {byte_i, shift_q};

    // Lane counter and partial word; held across rx_valid gaps
    always_ff @(posedge clk_i) begin
        if (!resetl_i || clear_i) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid_i) begin
            lane_q  <= w_last ? 2'd0 : lane_q + 2'd1;
            shift_q <= word_o[31:8];
        end
    end

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_program_loader
//  Description : Boot-time loader. Receives a framed byte image (header word
//                count, payload words, XOR checksum byte) over valid/ready,
//                writes words into instruction memory and releases the core
//                from reset once the image verifies.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter logic [63:0] BASE_PC     = 64'h0
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_resetl,
    output logic [63:0]       startpc,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0]   C_DEPTH     = 32'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] C_ONE     = (ADDR_W + 1)'(1);
    // Header and payload words share one packer, so it must cover the larger
    localparam int unsigned   C_PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;

    state_t            state_q;
    logic              rx_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              core_resetl_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W:0]   words_loaded_q;
    logic [ADDR_W:0]   n_q;
    logic [7:0]        csum_q;

    logic              w_accept;
    logic              w_pack_valid;
    logic              w_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_count_inc;

    assign w_accept     = rx_valid && rx_ready_q;
    assign w_pack_valid = w_accept && packs_bytes(state_q);
    assign w_clear      = start && can_start(state_q);
    assign w_count_inc  = words_loaded_q + C_ONE;

    byte_packer #(
        .BYTES        (C_PACK_BYTES)
    ) u_packer (
        .clk_i        (CLK),
        .resetl_i     (resetl),
        .clear_i      (w_clear),
        .byte_valid_i (w_pack_valid),
        .byte_i       (rx_data),
        .word_valid_o (w_word_valid),
        .word_o       (w_word)
    );

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q        <= ST_IDLE;
            rx_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'd0;
            core_resetl_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            n_q            <= '0;
            csum_q         <= 8'd0;
        end else begin
            imem_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    // The core leaves reset one cycle after the image verifies
                    if (state_q == ST_DONE) begin
                        core_resetl_q <= 1'b1;
                    end
                    if (start) begin
                        state_q        <= ST_HDR;
                        rx_ready_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        core_resetl_q  <= 1'b0;
                        words_loaded_q <= '0;
                        n_q            <= '0;
                        csum_q         <= 8'd0;
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        csum_q <= csum_q ^ rx_data;
                        if (w_word_valid) begin
                            if (w_word > C_DEPTH) begin
                                state_q    <= ST_ERR;
                                rx_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                            end else if (w_word == 32'd0) begin
                                state_q <= ST_CSUM;
                            end else begin
                                state_q <= ST_LOAD;
                                n_q     <= w_word[ADDR_W:0];
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        csum_q <= csum_q ^ rx_data;
                        if (w_word_valid) begin
                            imem_we_q      <= 1'b1;
                            imem_addr_q    <= words_loaded_q[ADDR_W-1:0];
                            imem_wdata_q   <= w_word;
                            words_loaded_q <= w_count_inc;
                            if (w_count_inc == n_q) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_resetl  = core_resetl_q;
    assign startpc      = BASE_PC;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule : imem_program_loader
`default_nettype wire
